// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA controller: a CPU write to DMA_REG_ADDR halts the CPU and copies
// XFER_LEN bytes from page {page,idx} to OAM_DATA_ADDR. Define OAM_DMA_ALIGN_EN for odd-cycle alignment.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int unsigned XFER_LEN      = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_we,
   output logic        cpu_rdy,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   input  logic [7:0]  mem_dout,
   output logic        dma_busy,
   output logic        dma_done
);

   localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      StIdle,
      StHalt,
      StAlign,
      StRead,
      StWrite,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic       align_req;

`ifdef OAM_DMA_ALIGN_EN
   // Free-running cycle parity; an odd HALT cycle needs one extra dummy cycle.
   logic parity_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= ~parity_q;
      end
   end

   assign align_req = parity_q;
`else
   assign align_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      idx_d    = idx_q;
      mem_addr = cpu_addr;
      mem_din  = cpu_dout;
      mem_we   = cpu_we;
      cpu_rdy  = 1'b1;
      dma_busy = 1'b1;
      dma_done = 1'b0;

      unique case (state_q)
         StIdle: begin
            dma_busy = 1'b0;
            // The trigger write itself still reaches memory through the passthrough.
            if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
               page_d  = cpu_dout;
               idx_d   = 8'h00;
               state_d = StHalt;
            end
         end
         StHalt: begin
            cpu_rdy  = 1'b0;
            mem_addr = {page_q, 8'h00};
            mem_din  = 8'h00;
            mem_we   = 1'b0;
            state_d  = align_req ? StAlign : StRead;
         end
         StAlign: begin
            cpu_rdy  = 1'b0;
            mem_addr = {page_q, 8'h00};
            mem_din  = 8'h00;
            mem_we   = 1'b0;
            state_d  = StRead;
         end
         StRead: begin
            cpu_rdy  = 1'b0;
            mem_addr = {page_q, idx_q};
            mem_din  = 8'h00;
            mem_we   = 1'b0;
            state_d  = StWrite;
         end
         StWrite: begin
            // mem_dout holds the byte addressed during the preceding READ cycle.
            cpu_rdy  = 1'b0;
            mem_addr = OAM_DATA_ADDR;
            mem_din  = mem_dout;
            mem_we   = 1'b1;
            idx_d    = idx_q + 8'd1;
            state_d  = (idx_q == LastIdx) ? StDone : StRead;
         end
         StDone: begin
            dma_done = 1'b1;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: a byte-wide memory model feeds the DMA; expected OAM
// writes, halt lengths and last source addresses are queued at trigger time and checked by a monitor.
module tb_oam_dma_ctrl;

   localparam logic [15:0] DmaReg  = 16'h4014;
   localparam logic [15:0] OamData = 16'h2004;
   localparam int          XLen    = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] cpu_addr = 16'h8000;
   logic [7:0]  cpu_dout = 8'h00;
   logic        cpu_we = 1'b0;
   logic        cpu_rdy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we;
   logic [7:0]  mem_dout;
   logic        dma_busy;
   logic        dma_done;

   oam_dma_ctrl #(
      .DMA_REG_ADDR (DmaReg),
      .OAM_DATA_ADDR(OamData),
      .XFER_LEN     (XLen)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .cpu_addr(cpu_addr),
      .cpu_dout(cpu_dout),
      .cpu_we  (cpu_we),
      .cpu_rdy (cpu_rdy),
      .mem_addr(mem_addr),
      .mem_din (mem_din),
      .mem_we  (mem_we),
      .mem_dout(mem_dout),
      .dma_busy(dma_busy),
      .dma_done(dma_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   int          len_q[$];
   logic [15:0] last_q[$];

   int          low_cnt = 0;
   int          zero_hits = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   logic [15:0] last_rd = 16'h0000;
   logic        tb_par = 1'b0;

   // Source pattern: page 03 holds i^A5, other pages a page-dependent pattern.
   function automatic logic [7:0] src_byte(input logic [15:0] a);
      if (a[15:8] == 8'h03) return a[7:0] ^ 8'hA5;
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // Memory model with one-cycle registered read.
   logic [7:0] mem [65536];
   logic [7:0] mem_rd_q = 8'h00;
   assign mem_dout = mem_rd_q;

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = src_byte(16'(a));
   end

   always @(posedge clk) begin
      mem_rd_q <= mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_din;
   end

   always @(posedge clk) tb_par <= reset ? 1'b0 : ~tb_par;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every OAM write and on every dma_done pulse.
   always @(negedge clk) begin
      if (reset) begin
         low_cnt   = 0;
         zero_hits = 0;
      end else begin
         if (!cpu_rdy) low_cnt++;
         if (!cpu_rdy && !mem_we) begin
            last_rd = mem_addr;
            if (mem_addr == 16'h0000) zero_hits++;
         end
         if (mem_we && mem_addr == OamData) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_oam_write", {24'h0, mem_din}, 32'hFFFF_FFFF);
            end else begin
               check("oam_write_data", {24'h0, mem_din}, {24'h0, exp_q.pop_front()});
            end
         end
         if (dma_done) begin
            done_cnt++;
            if (len_q.size() == 0 || last_q.size() == 0) begin
               check("unexpected_dma_done", 32'd1, 32'd0);
            end else begin
               check("rdy_low_cycles", low_cnt, len_q.pop_front());
               check("last_read_addr", {16'h0, last_rd}, {16'h0, last_q.pop_front()});
            end
            check("busy_in_done", {31'h0, dma_busy}, 32'd1);
            check("rdy_in_done", {31'h0, cpu_rdy}, 32'd1);
            check("no_addr_0000", zero_hits, 0);
            low_cnt   = 0;
            zero_hits = 0;
         end
      end
   end

   task automatic trigger(input logic [7:0] pg);
      @(posedge clk);
      #1;
      cpu_addr = DmaReg;
      cpu_dout = pg;
      cpu_we   = 1'b1;
      for (int i = 0; i < XLen; i++) exp_q.push_back(src_byte({pg, 8'(i)}));
      last_q.push_back({pg, 8'(XLen - 1)});
      @(negedge clk);
      check("trig_fwd_addr", {16'h0, mem_addr}, {16'h0, DmaReg});
      check("trig_fwd_we", {31'h0, mem_we}, 32'd1);
      check("trig_fwd_din", {24'h0, mem_din}, {24'h0, pg});
      @(posedge clk);
      #1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h8000;
      cpu_dout = 8'h00;
`ifdef OAM_DMA_ALIGN_EN
      len_q.push_back(1 + 2 * XLen + (tb_par ? 1 : 0));
`else
      len_q.push_back(1 + 2 * XLen);
`endif
   endtask

   task automatic wait_done();
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("dma_done_seen", {31'h0, done_cnt > start}, 32'd1);
      @(negedge clk);
      check("busy_after_done", {31'h0, dma_busy}, 32'd0);
   endtask

   initial begin
      int base;
      int n;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_rdy", {31'h0, cpu_rdy}, 32'd1);
      check("reset_busy", {31'h0, dma_busy}, 32'd0);
      check("reset_done", {31'h0, dma_done}, 32'd0);

      // Passthrough write to 4015 and read of 4014 never start a DMA.
      @(posedge clk);
      #1;
      cpu_addr = 16'h4015;
      cpu_dout = 8'h55;
      cpu_we   = 1'b1;
      @(negedge clk);
      check("pt_addr", {16'h0, mem_addr}, 32'h4015);
      check("pt_din", {24'h0, mem_din}, 32'h55);
      check("pt_we", {31'h0, mem_we}, 32'd1);
      @(posedge clk);
      #1;
      cpu_addr = DmaReg;
      cpu_we   = 1'b0;
      @(negedge clk);
      check("pt_rd_addr", {16'h0, mem_addr}, {16'h0, DmaReg});
      check("pt_rd_we", {31'h0, mem_we}, 32'd0);
      @(posedge clk);
      #1 cpu_addr = 16'h8000;
      repeat (5) @(negedge clk);
      check("pt_rdy", {31'h0, cpu_rdy}, 32'd1);
      check("pt_busy", {31'h0, dma_busy}, 32'd0);

      // Basic transfer from page 03, then page FF (no carry into page 00).
      trigger(8'h03);
      wait_done();
      trigger(8'hFF);
      wait_done();

      // A second trigger write during a WRITE cycle must be ignored.
      trigger(8'h03);
      n = 0;
      repeat (20) @(negedge clk);
      while (!(mem_we && mem_addr == OamData) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("found_write_phase", {31'h0, mem_we}, 32'd1);
      cpu_addr = DmaReg;
      cpu_dout = 8'h07;
      cpu_we   = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h8000;
      cpu_dout = 8'h00;
      wait_done();

      // Reset after the 10th OAM write aborts the transfer.
      base = wr_cnt;
      trigger(8'h03);
      n = 0;
      while (wr_cnt < base + 10 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("tenth_write_seen", wr_cnt, base + 10);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      len_q.delete();
      last_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_rdy", {31'h0, cpu_rdy}, 32'd1);
      check("abort_busy", {31'h0, dma_busy}, 32'd0);
      check("abort_done", {31'h0, dma_done}, 32'd0);
      repeat (600) @(negedge clk);
      check("no_write_after_abort", wr_cnt, base + 10);

      // A fresh trigger restarts from idx 0.
      trigger(8'h03);
      wait_done();

      check("dma_done_total", done_cnt, 4);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, CPU write address that triggers DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, destination address for every DMA write.
REQ-003 SHALL have parameter XFER_LEN, default 256, bytes per transfer (range 1..256).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port cpu_addr  in  16  CPU address bus.
REQ-007 SHALL have port cpu_dout  in  8  CPU write data.
REQ-008 SHALL have port cpu_we  in  1  CPU write strobe (inverse of R_W_n).
REQ-009 SHALL have port cpu_rdy  out  1  to 6502 rdy; low halts CPU.
REQ-010 SHALL have port mem_addr  out  16  shared memory address.
REQ-011 SHALL have port mem_din  out  8  shared memory write data.
REQ-012 SHALL have port mem_we  out  1  shared memory write enable.
REQ-013 SHALL have port mem_dout  in  8  shared memory read data; one-cycle registered read latency.
REQ-014 SHALL have port dma_busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port dma_done  out  1  one-cycle pulse at transfer end.

Function
REQ-016 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE, DONE.
REQ-017 IDLE: mem_addr/mem_din/mem_we SHALL pass cpu_addr/cpu_dout/cpu_we combinationally; cpu_rdy=1.
REQ-018 IDLE with cpu_we=1 and cpu_addr==DMA_REG_ADDR SHALL latch page=cpu_dout, clear idx, go HALT; the trigger write is still forwarded to memory.
REQ-019 HALT lasts exactly one cycle, then goes ALIGN if alignment required (REQ-031), else READ.
REQ-020 ALIGN lasts exactly one cycle, then READ.
REQ-021 READ: mem_addr={page,idx}, mem_we=0; next state WRITE.
REQ-022 WRITE: mem_addr=OAM_DATA_ADDR, mem_din=mem_dout, mem_we=1; idx increments; next READ, or DONE when idx==XFER_LEN-1.
REQ-023 DONE lasts one cycle: dma_done=1, cpu_rdy=1, bus returned to CPU passthrough, dma_busy=1; next IDLE.
REQ-024 cpu_rdy SHALL be 0 in HALT, ALIGN, READ, WRITE.
REQ-025 In HALT/ALIGN mem_we SHALL be 0 and mem_addr SHALL hold {page,8'h00}.
REQ-026 CPU bus inputs SHALL be ignored from HALT through WRITE, including further writes to DMA_REG_ADDR.
REQ-027 idx SHALL be 8 bits; source address SHALL never carry into page (page 8'hFF reads FF00..FFFF only).
REQ-028 Total cpu_rdy-low cycles SHALL be 1 + 2*XFER_LEN (+1 with ALIGN): 513/514 at default.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, page=0, idx=0, parity=0, dma_done=0, dma_busy=0, cpu_rdy=1, regardless of state.
REQ-030 Reset mid-transfer SHALL abort with no further mem_we from the controller; partial OAM contents are not restored.

Configuration
REQ-031 With OAM_DMA_ALIGN_EN defined: parity flop toggles every cycle from reset; HALT goes ALIGN when parity==1 in HALT; cpu_rdy-low length is 513 or 514.
REQ-032 Without OAM_DMA_ALIGN_EN: no parity flop, ALIGN unreachable, cpu_rdy-low length is always 1 + 2*XFER_LEN.

Verification
REQ-033 Memory 0x0300..0x03FF = i^8'hA5, CPU writes 8'h03 to 4014 (macro off) -> 256 writes to 2004 with data 8'hA5,8'hA4,...,8'h5A in order; cpu_rdy low 513 cycles; one dma_done pulse.
REQ-034 Macro on, trigger on even vs odd parity -> cpu_rdy low 513 vs 514 cycles; identical write data sequence.
REQ-035 Page 8'hFF trigger -> last read address 16'hFFFF, no access to 16'h0000.
REQ-036 Second write to 4014 (data 8'h07) during WRITE phase -> ignored; source page stays 8'h03, one dma_done.
REQ-037 reset pulsed after 10th write -> next cycle cpu_rdy=1, dma_busy=0, no further mem_we to 2004; new trigger restarts at idx 0.
REQ-038 CPU write to 16'h4015 and read of 16'h4014 -> passthrough only, no DMA, cpu_rdy stays 1.
